// File: rtl/bus_pkg.sv
// Shared types for the 8085-style bus responder.
// State encoding, status codes and the I/O window decode helper.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    RD,
    WR,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_FETCH = 2'b11
  } status_t;

  localparam int NPORTS = 4;

  // Offset compare wraps modulo 256, so a window near 8'hFF still works.
  function automatic logic io_hit(
    input logic [7:0] a,
    input logic [7:0] base
  );
    logic [7:0] off;
    off = a - base;
    return off < 8'(NPORTS);
  endfunction

endpackage

// File: rtl/bus_responder_mem.sv
// Byte array with synchronous write and registered read.
// Contents are deliberately left unreset.
module bus_responder_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_responder.sv
// Target-side responder for the multiplexed 8085-style bus:
// memory and I/O windows with programmable READY wait states.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          MEM_AW      = 8,
  parameter logic [7:0]  MEM_BASE_HI = 8'h20,
  parameter logic [7:0]  IO_BASE     = 8'hF0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        phi1,
  input  logic        resetn,
  input  logic        ALE,
  input  logic [7:0]  AD_in,
  input  logic [7:0]  A_hi,
  input  logic        IOMn,
  input  logic        S0,
  input  logic        S1,
  input  logic        RDn,
  input  logic        WRn,
  output logic [7:0]  AD_out,
  output logic        AD_oe,
  output logic        READY,
  output logic [31:0] io_regs,
  output logic        bus_err
);

  state_t            st;
  logic [15:0]       addr_q;
  logic              iom_q;
  status_t           stat_q;
  logic [2:0]        cnt;
  logic              rd_q;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic [MEM_AW-1:0] idx;
  logic [MEM_AW-1:0] ridx;
  logic [1:0]        port;
  logic [7:0]        io_byte;
  logic [7:0]        rd_byte;
  logic              mem_sel;
  logic              io_sel;
  logic              sel;
  logic              both;
  logic              commit;
  logic              mem_we;
  logic              unused_ok;

  assign idx     = addr_q[MEM_AW-1:0];
  assign port    = addr_q[1:0];
  assign mem_sel = ~iom_q & (addr_q[15:8] == MEM_BASE_HI);
  assign io_sel  = iom_q & io_hit(addr_q[7:0], IO_BASE);
  assign sel     = mem_sel | io_sel;
  assign both    = ~RDn & ~WRn;
  assign io_byte = io_regs[{port, 3'b000} +: 8];
  assign rd_byte = io_sel ? io_byte : rdata;
  assign commit  = (st == WR) & WRn & ~ALE;
  assign mem_we  = commit & mem_sel & resetn;
  assign unused_ok = ^stat_q;

  // Read the incoming address on the ALE edge so data is ready
  // even when the strobe is sampled on the very next edge.
  assign ridx = ALE ? AD_in[MEM_AW-1:0] : idx;

  bus_responder_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk  (phi1),
    .we   (mem_we),
    .waddr(idx),
    .wdata(wdata),
    .raddr(ridx),
    .rdata(rdata)
  );

  always_ff @(posedge phi1 or negedge resetn) begin
    if (!resetn) begin
      st      <= IDLE;
      addr_q  <= '0;
      iom_q   <= 1'b0;
      stat_q  <= ST_HALT;
      cnt     <= '0;
      rd_q    <= 1'b0;
      wdata   <= '0;
      AD_out  <= '0;
      AD_oe   <= 1'b0;
      READY   <= 1'b1;
      io_regs <= '0;
      bus_err <= 1'b0;
    end else begin
      if (both)
        bus_err <= 1'b1;
      if (ALE) begin
        addr_q <= {A_hi, AD_in};
        iom_q  <= IOMn;
        stat_q <= status_t'({S1, S0});
        st     <= ADDR;
        cnt    <= '0;
        AD_oe  <= 1'b0;
        READY  <= 1'b1;
      end else if (both) begin
        st    <= DONE;
        AD_oe <= 1'b0;
        READY <= 1'b1;
      end else begin
        if (!WRn)
          wdata <= AD_in;
        unique case (st)
          IDLE: begin
            if (!RDn || !WRn)
              bus_err <= 1'b1;
          end
          ADDR: begin
            if (!RDn || !WRn) begin
              rd_q <= ~RDn;
              cnt  <= 3'(WAIT_STATES);
              if (!sel) begin
                st <= DONE;
              end else if (WAIT_STATES == 0) begin
                st <= RDn ? WR : RD;
                if (!RDn) begin
                  AD_oe  <= 1'b1;
                  AD_out <= rd_byte;
                end
              end else begin
                READY <= 1'b0;
                st    <= WAIT;
              end
            end
          end
          WAIT: begin
            if (cnt <= 3'd1) begin
              READY <= 1'b1;
              st    <= rd_q ? RD : WR;
              if (rd_q) begin
                AD_oe  <= 1'b1;
                AD_out <= rd_byte;
              end
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          RD: begin
            if (RDn) begin
              AD_oe <= 1'b0;
              st    <= DONE;
            end
          end
          WR: begin
            if (WRn) begin
              if (io_sel)
                io_regs[{port, 3'b000} +: 8] <= wdata;
              st <= DONE;
            end
          end
          DONE: begin
            if (RDn && WRn)
              st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a WAIT_STATES=1 and a
// WAIT_STATES=3 instance share the same bus stimulus.
module tb_bus_responder;

  logic        phi1 = 1'b0;
  logic        resetn = 1'b0;
  logic        ALE = 1'b0;
  logic [7:0]  AD_in = '0;
  logic [7:0]  A_hi = '0;
  logic        IOMn = 1'b0;
  logic        S0 = 1'b0;
  logic        S1 = 1'b0;
  logic        RDn = 1'b1;
  logic        WRn = 1'b1;

  logic [7:0]  ad1, ad3;
  logic        oe1, oe3;
  logic        rdy1, rdy3;
  logic [31:0] io1, io3;
  logic        err1, err3;

  int total = 0;
  int bad = 0;

  always #5 phi1 = ~phi1;

  bus_responder #(.WAIT_STATES(1)) u_dut1 (
    .phi1(phi1), .resetn(resetn), .ALE(ALE),
    .AD_in(AD_in), .A_hi(A_hi), .IOMn(IOMn),
    .S0(S0), .S1(S1), .RDn(RDn), .WRn(WRn),
    .AD_out(ad1), .AD_oe(oe1), .READY(rdy1),
    .io_regs(io1), .bus_err(err1)
  );

  bus_responder #(.WAIT_STATES(3)) u_dut3 (
    .phi1(phi1), .resetn(resetn), .ALE(ALE),
    .AD_in(AD_in), .A_hi(A_hi), .IOMn(IOMn),
    .S0(S0), .S1(S1), .RDn(RDn), .WRn(WRn),
    .AD_out(ad3), .AD_oe(oe3), .READY(rdy3),
    .io_regs(io3), .bus_err(err3)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge phi1);
    #1;
  endtask

  task automatic addr_ph(input logic iom, input logic [15:0] a);
    ALE   = 1'b1;
    IOMn  = iom;
    A_hi  = a[15:8];
    AD_in = a[7:0];
    cyc();
    ALE = 1'b0;
  endtask

  // Count READY-low cycles of each instance, bounded.
  task automatic wait_rdy(output int n1, output int n3);
    n1 = 0;
    n3 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!rdy1) n1++;
      if (!rdy3) n3++;
      if (rdy1 && rdy3) break;
    end
  endtask

  task automatic do_wr(
    input string       tag,
    input logic        iom,
    input logic [15:0] a,
    input logic [7:0]  d,
    input int          e1,
    input int          e3
  );
    int n1, n3;
    addr_ph(iom, a);
    WRn   = 1'b0;
    AD_in = d;
    wait_rdy(n1, n3);
    chk({tag, "_rdy1"}, n1, e1);
    chk({tag, "_rdy3"}, n3, e3);
    WRn = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic do_rd(
    input string       tag,
    input logic        iom,
    input logic [15:0] a,
    input logic        hit,
    input logic [7:0]  d
  );
    int n1, n3;
    addr_ph(iom, a);
    RDn = 1'b0;
    wait_rdy(n1, n3);
    chk({tag, "_rdy1"}, n1, hit ? 1 : 0);
    chk({tag, "_rdy3"}, n3, hit ? 3 : 0);
    chk({tag, "_oe1"}, oe1, hit);
    chk({tag, "_oe3"}, oe3, hit);
    if (hit) begin
      chk({tag, "_d1"}, ad1, d);
      chk({tag, "_d3"}, ad3, d);
    end
    RDn = 1'b1;
    cyc();
    chk({tag, "_oe_off"}, oe1, 1'b0);
    cyc();
  endtask

  initial begin
    int n1, n3;
    #12;
    chk("rst_oe", oe1, 1'b0);
    chk("rst_rdy", rdy1, 1'b1);
    chk("rst_rdy3", rdy3, 1'b1);
    chk("rst_err", err1, 1'b0);
    chk("rst_io", io1, 32'h0);
    chk("rst_ad", ad1, 8'h00);
    resetn = 1'b1;
    cyc();

    do_wr("mw34", 1'b0, 16'h2034, 8'hA5, 1, 3);
    do_wr("mw35", 1'b0, 16'h2035, 8'h5A, 1, 3);
    do_rd("mr34", 1'b0, 16'h2034, 1'b1, 8'hA5);
    do_rd("mr35", 1'b0, 16'h2035, 1'b1, 8'h5A);

    do_wr("iow2", 1'b1, 16'h00F2, 8'h3C, 1, 3);
    chk("io_f2", io1, 32'h003C_0000);
    chk("io_f2_3", io3, 32'h003C_0000);
    do_wr("iow4", 1'b1, 16'h00F4, 8'h77, 0, 0);
    chk("io_f4", io1, 32'h003C_0000);
    do_rd("ior2", 1'b1, 16'h00F2, 1'b1, 8'h3C);
    do_rd("ior4", 1'b1, 16'h00F4, 1'b0, 8'h00);

    do_rd("oow", 1'b0, 16'h3034, 1'b0, 8'h00);
    chk("oow_err", err1, 1'b0);

    // Abort a write with ALE before WRn rises.
    addr_ph(1'b0, 16'h2034);
    WRn   = 1'b0;
    AD_in = 8'hFF;
    wait_rdy(n1, n3);
    ALE   = 1'b1;
    A_hi  = 8'h20;
    AD_in = 8'h34;
    WRn   = 1'b1;
    cyc();
    ALE = 1'b0;
    cyc();
    do_rd("abort", 1'b0, 16'h2034, 1'b1, 8'hA5);

    // Both strobes low together.
    addr_ph(1'b0, 16'h2035);
    RDn   = 1'b0;
    WRn   = 1'b0;
    AD_in = 8'h00;
    cyc();
    chk("both_err1", err1, 1'b1);
    chk("both_err3", err3, 1'b1);
    chk("both_oe", oe1, 1'b0);
    RDn = 1'b1;
    WRn = 1'b1;
    cyc();
    cyc();
    do_rd("after_err", 1'b0, 16'h2035, 1'b1, 8'h5A);
    chk("err_sticky", err1, 1'b1);

    // Reset in the middle of a read.
    addr_ph(1'b0, 16'h2034);
    RDn = 1'b0;
    wait_rdy(n1, n3);
    chk("mid_oe1", oe1, 1'b1);
    chk("mid_oe3", oe3, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_oe1", oe1, 1'b0);
    chk("arst_oe3", oe3, 1'b0);
    chk("arst_rdy", rdy1, 1'b1);
    chk("arst_io", io1, 32'h0);
    chk("arst_err", err1, 1'b0);
    RDn = 1'b1;
    cyc();
    resetn = 1'b1;
    cyc();
    do_rd("post_rst", 1'b0, 16'h2034, 1'b1, 8'hA5);

    // Strobe with no address phase.
    RDn = 1'b0;
    cyc();
    chk("idle_err", err1, 1'b1);
    chk("idle_oe", oe1, 1'b0);
    RDn = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
